pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline control unit for the 5-stage MIPS core. It replaces the ad-hoc forwarding and stall glue with one block that owns operand forwarding, load-use stalls with configurable load latency, redirect flushes over a configurable depth, and data-memory wait freezes. It drives per-stage enable and flush strobes into every pipeline register of the datapath and keeps stall and flush performance counters.

Parameters:
AWIDTH, 5, register address width
LOAD_LAT, 1, extra cycles a load needs beyond MEM; load-use stall length is 1+LOAD_LAT (range 0..7)
FLUSH_DEPTH, 2, number of younger stages squashed on a redirect (1..3: IF/ID, ID/EX, EX/MEM)
CNT_WIDTH, 32, width of performance counters

Ports:
hz_clk  in  1  clock
hz_rst  in  1  asynchronous active-low reset
hz_i_ce  in  1  global enable; low freezes FSM, counters and all stage enables
hz_i_id_rs, hz_i_id_rt  in  AWIDTH  source registers of instruction in decode
hz_i_id_use_rt  in  1  decode instruction reads rt (R-type, store, branch)
hz_i_ex_rs, hz_i_ex_rt  in  AWIDTH  source registers held in ID/EX
hz_i_ex_rd  in  AWIDTH  destination held in ID/EX
hz_i_ex_regwr, hz_i_ex_memtoreg  in  1  ID/EX write-back and load flags
hz_i_mem_rd  in  AWIDTH; hz_i_mem_regwr, hz_i_mem_memtoreg  in  1  EX/MEM destination and flags
hz_i_wb_rd  in  AWIDTH; hz_i_wb_regwr  in  1  MEM/WB destination and flag
hz_i_redirect  in  1  taken branch/jump/jr resolved in EX
hz_i_mem_busy  in  1  data memory not ready
hz_o_fwd_rs, hz_o_fwd_rt  out  2  EX operand select: 00 register file, 01 EX/MEM ALU value, 10 write-back data
hz_o_pc_en, hz_o_ifid_en, hz_o_exmem_en, hz_o_memwb_en  out  1  stage register enables
hz_o_ifid_flush, hz_o_idex_flush, hz_o_exmem_flush  out  1  load bubble (all control zero) into stage
hz_o_stall_cnt, hz_o_flush_cnt  out  CNT_WIDTH  performance counters

Behaviour:
- Reset (hz_rst low, any time, also mid-stall/mid-flush): FSM to RUN, internal counter 0, perf counters 0, all enables 0, all flushes 0, fwd selects 00. First cycle after release is RUN.
- Forwarding (combinational, independent of FSM): a source equal to 0 never forwards. EX/MEM match (mem_regwr, rd==src, mem_memtoreg=0) gives 01. Otherwise MEM/WB match (wb_regwr, rd==src) gives 10. Otherwise 00. EX/MEM wins when both match.
- Load-use hazard: ex_regwr & ex_memtoreg & ex_rd!=0 & (ex_rd==id_rs | (id_use_rt & ex_rd==id_rt)).
- Priority per cycle: !hz_i_ce > mem_busy > redirect > load-use.
- FSM states: RUN, LSTALL, FLUSH, MWAIT.
- RUN: normal enables 1, flushes 0. On redirect: assert flushes on the first FLUSH_DEPTH stages (ifid, idex, exmem) this cycle; go to FLUSH if FLUSH_DEPTH>1 so deeper squashes stay asserted as the wrong path advances, else stay in RUN. On load-use: pc_en=0, ifid_en=0, idex_flush=1; counter=LOAD_LAT; go LSTALL if LOAD_LAT>0.
- LSTALL: same strobes as load-use; decrement counter; exit to RUN when counter reaches 0. Total bubbles = 1+LOAD_LAT. A redirect arriving in LSTALL aborts the stall and is handled as in RUN.
- FLUSH: keeps ifid_flush=1 for FLUSH_DEPTH-1 further cycles, then RUN.
- MWAIT, entered from any state on mem_busy: all enables 0, all flushes 0; the prior state and counter are saved and resumed on the cycle after mem_busy drops. Forwarding stays live.
- hz_i_ce low: outputs as in MWAIT, nothing advances.
- Counters: stall_cnt increments on every cycle with pc_en=0 due to load-use or MWAIT; flush_cnt increments once per accepted redirect. Both saturate at all-ones and never wrap.

Decomposition:
- Shared package/header: FSM state encodings, fwd select constants (FWD_REG, FWD_MEM, FWD_WB), CNT_WIDTH default.
- One sub-module: hz_fwd_unit (the combinational forwarding compare, instanced once per operand).

Test Plan:
- lw $2 in EX, add $3,$2,$4 in decode, LOAD_LAT=1 -> pc_en/ifid_en low and idex_flush high for exactly 2 cycles; stall_cnt=2.
- add $5 in EX/MEM and MEM/WB both writing $5, EX reads $5 -> fwd_rs=01; $0 destination with match -> 00.
- Redirect with FLUSH_DEPTH=2 -> ifid_flush and idex_flush high in the redirect cycle, ifid_flush high one more cycle, exmem_flush low; flush_cnt=1.
- mem_busy held 3 cycles during LSTALL (counter=1) -> all enables 0 for 3 cycles, then 1 further stall cycle, then RUN.
- Redirect during LSTALL -> stall aborted, flush sequence runs, no extra bubble cycles.
- hz_rst pulled low in FLUSH with stall_cnt=7 -> outputs and counters 0 immediately; RUN after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_MWAIT  = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int unsigned CNT_WIDTH_DEF = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Combinational operand-forwarding select for one EX source register.
module hz_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH = 5
) (
    input  logic [AWIDTH-1:0] src,
    input  logic [AWIDTH-1:0] mem_rd,
    input  logic              mem_regwr,
    input  logic              mem_memtoreg,
    input  logic [AWIDTH-1:0] wb_rd,
    input  logic              wb_regwr,
    output logic [1:0]        sel
);

    // A load in EX/MEM has no ALU result to forward; its data arrives via WB.
    always_comb begin
        sel = FWD_REG;
        if (src != '0) begin
            if (mem_regwr && !mem_memtoreg && (mem_rd == src)) begin
                sel = FWD_MEM;
            end else if (wb_regwr && (wb_rd == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: forwarding, load-use stalls, redirect flushes, memory-wait freeze, perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH      = 5,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                 hz_clk,
    input  logic                 hz_rst,
    input  logic                 hz_i_ce,
    input  logic [AWIDTH-1:0]    hz_i_id_rs,
    input  logic [AWIDTH-1:0]    hz_i_id_rt,
    input  logic                 hz_i_id_use_rt,
    input  logic [AWIDTH-1:0]    hz_i_ex_rs,
    input  logic [AWIDTH-1:0]    hz_i_ex_rt,
    input  logic [AWIDTH-1:0]    hz_i_ex_rd,
    input  logic                 hz_i_ex_regwr,
    input  logic                 hz_i_ex_memtoreg,
    input  logic [AWIDTH-1:0]    hz_i_mem_rd,
    input  logic                 hz_i_mem_regwr,
    input  logic                 hz_i_mem_memtoreg,
    input  logic [AWIDTH-1:0]    hz_i_wb_rd,
    input  logic                 hz_i_wb_regwr,
    input  logic                 hz_i_redirect,
    input  logic                 hz_i_mem_busy,
    output logic [1:0]           hz_o_fwd_rs,
    output logic [1:0]           hz_o_fwd_rt,
    output logic                 hz_o_pc_en,
    output logic                 hz_o_ifid_en,
    output logic                 hz_o_exmem_en,
    output logic                 hz_o_memwb_en,
    output logic                 hz_o_ifid_flush,
    output logic                 hz_o_idex_flush,
    output logic                 hz_o_exmem_flush,
    output logic [CNT_WIDTH-1:0] hz_o_stall_cnt,
    output logic [CNT_WIDTH-1:0] hz_o_flush_cnt
);

    hz_state_t  state, next_state, saved, next_saved, cur;
    logic [2:0] cnt, next_cnt;
    logic       load_use, stall_inc, flush_inc;
    logic [1:0] fwd_rs, fwd_rt;

    hz_fwd_unit #(.AWIDTH(AWIDTH)) u_fwd_rs (
        .src(hz_i_ex_rs), .mem_rd(hz_i_mem_rd), .mem_regwr(hz_i_mem_regwr),
        .mem_memtoreg(hz_i_mem_memtoreg), .wb_rd(hz_i_wb_rd), .wb_regwr(hz_i_wb_regwr),
        .sel(fwd_rs)
    );

    hz_fwd_unit #(.AWIDTH(AWIDTH)) u_fwd_rt (
        .src(hz_i_ex_rt), .mem_rd(hz_i_mem_rd), .mem_regwr(hz_i_mem_regwr),
        .mem_memtoreg(hz_i_mem_memtoreg), .wb_rd(hz_i_wb_rd), .wb_regwr(hz_i_wb_regwr),
        .sel(fwd_rt)
    );

    assign hz_o_fwd_rs = hz_rst ? fwd_rs : FWD_REG;
    assign hz_o_fwd_rt = hz_rst ? fwd_rt : FWD_REG;

    assign load_use = hz_i_ex_regwr && hz_i_ex_memtoreg && (hz_i_ex_rd != '0) &&
                      ((hz_i_ex_rd == hz_i_id_rs) || (hz_i_id_use_rt && (hz_i_ex_rd == hz_i_id_rt)));

    // MWAIT only freezes; the interrupted state is evaluated as if never left.
    assign cur = (state == ST_MWAIT) ? saved : state;

    always_comb begin
        next_state       = state;
        next_saved       = saved;
        next_cnt         = cnt;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;
        hz_o_pc_en       = 1'b0;
        hz_o_ifid_en     = 1'b0;
        hz_o_exmem_en    = 1'b0;
        hz_o_memwb_en    = 1'b0;
        hz_o_ifid_flush  = 1'b0;
        hz_o_idex_flush  = 1'b0;
        hz_o_exmem_flush = 1'b0;
        if (hz_rst && hz_i_ce) begin
            if (hz_i_mem_busy) begin
                next_state = ST_MWAIT;
                next_saved = cur;
                stall_inc  = 1'b1;
            end else begin
                hz_o_pc_en    = 1'b1;
                hz_o_ifid_en  = 1'b1;
                hz_o_exmem_en = 1'b1;
                hz_o_memwb_en = 1'b1;
                next_state    = cur;
                if (hz_i_redirect) begin
                    hz_o_ifid_flush  = 1'b1;
                    hz_o_idex_flush  = (FLUSH_DEPTH >= 2);
                    hz_o_exmem_flush = (FLUSH_DEPTH >= 3);
                    flush_inc        = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        next_state = ST_FLUSH;
                        next_cnt   = 3'(FLUSH_DEPTH - 1);
                    end else begin
                        next_state = ST_RUN;
                    end
                end else begin
                    case (cur)
                        ST_LSTALL: begin
                            hz_o_pc_en      = 1'b0;
                            hz_o_ifid_en    = 1'b0;
                            hz_o_idex_flush = 1'b1;
                            stall_inc       = 1'b1;
                            next_cnt        = cnt - 3'd1;
                            if (cnt == 3'd1) next_state = ST_RUN;
                        end
                        ST_FLUSH: begin
                            hz_o_ifid_flush = 1'b1;
                            next_cnt        = cnt - 3'd1;
                            if (cnt == 3'd1) next_state = ST_RUN;
                        end
                        default: begin
                            next_state = ST_RUN;
                            if (load_use) begin
                                hz_o_pc_en      = 1'b0;
                                hz_o_ifid_en    = 1'b0;
                                hz_o_idex_flush = 1'b1;
                                stall_inc       = 1'b1;
                                if (LOAD_LAT > 0) begin
                                    next_state = ST_LSTALL;
                                    next_cnt   = 3'(LOAD_LAT);
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge hz_clk or negedge hz_rst) begin
        if (!hz_rst) begin
            state          <= ST_RUN;
            saved          <= ST_RUN;
            cnt            <= '0;
            hz_o_stall_cnt <= '0;
            hz_o_flush_cnt <= '0;
        end else begin
            state <= next_state;
            saved <= next_saved;
            cnt   <= next_cnt;
            if (stall_inc && (hz_o_stall_cnt != '1)) hz_o_stall_cnt <= hz_o_stall_cnt + CNT_WIDTH'(1);
            if (flush_inc && (hz_o_flush_cnt != '1)) hz_o_flush_cnt <= hz_o_flush_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized run against a cycle model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned LL = 1;
    localparam int unsigned FD = 2;
    localparam int unsigned CW = 4;

    localparam logic [6:0] C_RUN   = 7'b1111000;
    localparam logic [6:0] C_STALL = 7'b0011010;
    localparam logic [6:0] C_REDIR = 7'b1111110;
    localparam logic [6:0] C_FLUSH = 7'b1111100;
    localparam logic [6:0] C_FROZE = 7'b0000000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce;
    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic          id_use_rt, ex_regwr, ex_memtoreg, mem_regwr, mem_memtoreg, wb_regwr;
    logic          redirect, mem_busy;
    logic [1:0]    fwd_rs, fwd_rt;
    logic          pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    ctl;

    int errors = 0;
    int checks = 0;

    int            m_sl, m_fl, n_sl, n_fl;
    logic [CW-1:0] m_stall, m_flush, n_stall, n_flush;
    logic [6:0]    e_ctl;
    logic [1:0]    e_rs, e_rt;

    assign ctl = {pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.AWIDTH(AW), .LOAD_LAT(LL), .FLUSH_DEPTH(FD), .CNT_WIDTH(CW)) dut (
        .hz_clk(clk), .hz_rst(rst), .hz_i_ce(ce),
        .hz_i_id_rs(id_rs), .hz_i_id_rt(id_rt), .hz_i_id_use_rt(id_use_rt),
        .hz_i_ex_rs(ex_rs), .hz_i_ex_rt(ex_rt), .hz_i_ex_rd(ex_rd),
        .hz_i_ex_regwr(ex_regwr), .hz_i_ex_memtoreg(ex_memtoreg),
        .hz_i_mem_rd(mem_rd), .hz_i_mem_regwr(mem_regwr), .hz_i_mem_memtoreg(mem_memtoreg),
        .hz_i_wb_rd(wb_rd), .hz_i_wb_regwr(wb_regwr),
        .hz_i_redirect(redirect), .hz_i_mem_busy(mem_busy),
        .hz_o_fwd_rs(fwd_rs), .hz_o_fwd_rt(fwd_rt),
        .hz_o_pc_en(pc_en), .hz_o_ifid_en(ifid_en), .hz_o_exmem_en(exmem_en), .hz_o_memwb_en(memwb_en),
        .hz_o_ifid_flush(ifid_flush), .hz_o_idex_flush(idex_flush), .hz_o_exmem_flush(exmem_flush),
        .hz_o_stall_cnt(stall_cnt), .hz_o_flush_cnt(flush_cnt)
    );

    task automatic idle();
        ce = 1'b1; id_rs = '0; id_rt = '0; id_use_rt = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_regwr = 1'b0; ex_memtoreg = 1'b0;
        mem_rd = '0; mem_regwr = 1'b0; mem_memtoreg = 1'b0;
        wb_rd = '0; wb_regwr = 1'b0; redirect = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
    endtask

    // lw $2 in EX, add $3,$2,$4 in decode
    task automatic set_load_use();
        ex_regwr = 1'b1; ex_memtoreg = 1'b1; ex_rd = AW'(2);
        id_rs = AW'(2); id_rt = AW'(4); id_use_rt = 1'b1;
    endtask

    task automatic set_bubble();
        ex_regwr = 1'b0; ex_memtoreg = 1'b0; ex_rd = '0;
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] src);
        if (src == 0) return 2'b00;
        if (mem_regwr && !mem_memtoreg && mem_rd == src) return 2'b01;
        if (wb_regwr && wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    // Cycle model in terms of "bubbles still owed" and "flush cycles still owed".
    task automatic model_eval();
        logic hazard;
        hazard = ex_regwr && ex_memtoreg && (ex_rd != 0) &&
                 ((ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
        n_sl = m_sl; n_fl = m_fl; n_stall = m_stall; n_flush = m_flush;
        e_ctl = C_FROZE;
        e_rs = ref_fwd(ex_rs);
        e_rt = ref_fwd(ex_rt);
        if (!rst) begin
            e_rs = 2'b00; e_rt = 2'b00;
            m_sl = 0; m_fl = 0; m_stall = '0; m_flush = '0;
            n_sl = 0; n_fl = 0; n_stall = '0; n_flush = '0;
        end else if (!ce) begin
            e_ctl = C_FROZE;
        end else if (mem_busy) begin
            n_stall = sat_inc(m_stall);
        end else if (redirect) begin
            e_ctl = {4'b1111, 1'b1, FD >= 2, FD >= 3};
            n_flush = sat_inc(m_flush);
            n_sl = 0;
            n_fl = FD - 1;
        end else if (m_sl > 0) begin
            e_ctl = C_STALL; n_sl = m_sl - 1; n_stall = sat_inc(m_stall);
        end else if (m_fl > 0) begin
            e_ctl = C_FLUSH; n_fl = m_fl - 1;
        end else if (hazard) begin
            e_ctl = C_STALL; n_sl = LL; n_stall = sat_inc(m_stall);
        end else begin
            e_ctl = C_RUN;
        end
    endtask

    task automatic test_reset();
        idle();
        redirect = 1'b1; mem_rd = AW'(5); mem_regwr = 1'b1; ex_rs = AW'(5);
        #2;
        checks++; if (ctl !== C_FROZE) begin errors++; $display("FAIL rst_ctl got=%b want=%b", ctl, C_FROZE); end
        checks++; if (fwd_rs !== 2'b00) begin errors++; $display("FAIL rst_fwd got=%b want=00", fwd_rs); end
        checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt); end
        tick();
        checks++; if (ctl !== C_FROZE) begin errors++; $display("FAIL rst_ctl_edge got=%b want=%b", ctl, C_FROZE); end
        idle();
        rst = 1'b1;
        #2;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL rst_release got=%b want=%b", ctl, C_RUN); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset(); idle();
        set_load_use();
        #2;
        checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL lu_c1 got=%b want=%b", ctl, C_STALL); end
        tick();
        set_bubble();
        #2;
        checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL lu_c2 got=%b want=%b", ctl, C_STALL); end
        tick();
        #2;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_end got=%b want=%b", ctl, C_RUN); end
        checks++; if (stall_cnt !== CW'(2)) begin errors++; $display("FAIL lu_cnt got=%0d want=2", stall_cnt); end
        // rt only counts when the decode instruction reads it; $0 never stalls
        ex_regwr = 1'b1; ex_memtoreg = 1'b1; ex_rd = AW'(2); id_rs = AW'(4); id_rt = AW'(2); id_use_rt = 1'b0;
        #2;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_rt_unused got=%b want=%b", ctl, C_RUN); end
        id_use_rt = 1'b1;
        #2;
        checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL lu_rt_used got=%b want=%b", ctl, C_STALL); end
        ex_rd = '0; id_rs = '0; id_rt = '0;
        #2;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_r0 got=%b want=%b", ctl, C_RUN); end
        idle();
        tick();
    endtask

    task automatic test_forwarding();
        do_reset(); idle();
        mem_rd = AW'(5); mem_regwr = 1'b1; wb_rd = AW'(5); wb_regwr = 1'b1; ex_rs = AW'(5); ex_rt = AW'(5);
        #1;
        checks++; if (fwd_rs !== 2'b01 || fwd_rt !== 2'b01) begin errors++; $display("FAIL fwd_mem_wins got=%b/%b want=01/01", fwd_rs, fwd_rt); end
        mem_busy = 1'b1;
        #1;
        checks++; if (fwd_rs !== 2'b01) begin errors++; $display("FAIL fwd_live_busy got=%b want=01", fwd_rs); end
        mem_busy = 1'b0; mem_memtoreg = 1'b1;
        #1;
        checks++; if (fwd_rs !== 2'b10) begin errors++; $display("FAIL fwd_load_wb got=%b want=10", fwd_rs); end
        mem_memtoreg = 1'b0; mem_regwr = 1'b0; ex_rt = AW'(7);
        #1;
        checks++; if (fwd_rs !== 2'b10 || fwd_rt !== 2'b00) begin errors++; $display("FAIL fwd_wb_only got=%b/%b want=10/00", fwd_rs, fwd_rt); end
        wb_regwr = 1'b0;
        #1;
        checks++; if (fwd_rs !== 2'b00) begin errors++; $display("FAIL fwd_none got=%b want=00", fwd_rs); end
        mem_rd = '0; mem_regwr = 1'b1; wb_rd = '0; wb_regwr = 1'b1; ex_rs = '0; ex_rt = '0;
        #1;
        checks++; if (fwd_rs !== 2'b00 || fwd_rt !== 2'b00) begin errors++; $display("FAIL fwd_r0 got=%b/%b want=00/00", fwd_rs, fwd_rt); end
        idle();
        tick();
    endtask

    task automatic test_redirect();
        do_reset(); idle();
        redirect = 1'b1;
        #2;
        checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL redir_c0 got=%b want=%b", ctl, C_REDIR); end
        tick();
        redirect = 1'b0;
        #2;
        checks++; if (ctl !== C_FLUSH) begin errors++; $display("FAIL redir_c1 got=%b want=%b", ctl, C_FLUSH); end
        tick();
        #2;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL redir_end got=%b want=%b", ctl, C_RUN); end
        checks++; if (flush_cnt !== CW'(1) || stall_cnt !== '0) begin errors++; $display("FAIL redir_cnt got=%0d/%0d want=1/0", flush_cnt, stall_cnt); end
        tick();
    endtask

    task automatic test_busy_in_stall();
        do_reset(); idle();
        set_load_use();
        #2;
        checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL busy_lu got=%b want=%b", ctl, C_STALL); end
        tick();
        set_bubble();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if (ctl !== C_FROZE) begin errors++; $display("FAIL busy_frozen%0d got=%b want=%b", i, ctl, C_FROZE); end
            tick();
        end
        mem_busy = 1'b0;
        #2;
        checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL busy_resume got=%b want=%b", ctl, C_STALL); end
        tick();
        #2;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL busy_end got=%b want=%b", ctl, C_RUN); end
        checks++; if (stall_cnt !== CW'(5)) begin errors++; $display("FAIL busy_cnt got=%0d want=5", stall_cnt); end
        tick();
    endtask

    task automatic test_redirect_in_stall();
        do_reset(); idle();
        set_load_use();
        #2;
        tick();
        set_bubble();
        redirect = 1'b1;
        #2;
        checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL rds_c0 got=%b want=%b", ctl, C_REDIR); end
        tick();
        redirect = 1'b0;
        #2;
        checks++; if (ctl !== C_FLUSH) begin errors++; $display("FAIL rds_c1 got=%b want=%b", ctl, C_FLUSH); end
        tick();
        #2;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL rds_end got=%b want=%b", ctl, C_RUN); end
        checks++; if (stall_cnt !== CW'(1) || flush_cnt !== CW'(1)) begin errors++; $display("FAIL rds_cnt got=%0d/%0d want=1/1", stall_cnt, flush_cnt); end
        tick();
    endtask

    task automatic test_ce();
        do_reset(); idle();
        set_load_use();
        #2;
        tick();
        set_bubble();
        ce = 1'b0; mem_rd = AW'(3); mem_regwr = 1'b1; ex_rs = AW'(3);
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++; if (ctl !== C_FROZE || fwd_rs !== 2'b01) begin errors++; $display("FAIL ce_hold%0d got=%b/%b want=%b/01", i, ctl, fwd_rs, C_FROZE); end
            tick();
        end
        checks++; if (stall_cnt !== CW'(1)) begin errors++; $display("FAIL ce_cnt_hold got=%0d want=1", stall_cnt); end
        ce = 1'b1;
        #2;
        checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL ce_resume got=%b want=%b", ctl, C_STALL); end
        tick();
        checks++; if (stall_cnt !== CW'(2)) begin errors++; $display("FAIL ce_cnt got=%0d want=2", stall_cnt); end
        idle();
        tick();
    endtask

    task automatic test_reset_in_flush();
        do_reset(); idle();
        mem_busy = 1'b1;
        repeat (7) tick();
        mem_busy = 1'b0; redirect = 1'b1;
        #2;
        tick();
        redirect = 1'b0;
        #1;
        checks++; if (ctl !== C_FLUSH || stall_cnt !== CW'(7)) begin errors++; $display("FAIL rif_pre got=%b/%0d want=%b/7", ctl, stall_cnt, C_FLUSH); end
        mem_rd = AW'(5); mem_regwr = 1'b1; ex_rs = AW'(5);
        rst = 1'b0;
        #1;
        checks++; if (ctl !== C_FROZE || fwd_rs !== 2'b00) begin errors++; $display("FAIL rif_out got=%b/%b want=%b/00", ctl, fwd_rs, C_FROZE); end
        checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL rif_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt); end
        tick();
        idle();
        rst = 1'b1;
        #1;
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL rif_release got=%b want=%b", ctl, C_RUN); end
        tick();
        checks++; if (ctl !== C_RUN || stall_cnt !== '0) begin errors++; $display("FAIL rif_run got=%b/%0d want=%b/0", ctl, stall_cnt, C_RUN); end
    endtask

    task automatic test_saturation();
        do_reset(); idle();
        mem_busy = 1'b1;
        repeat (20) tick();
        checks++; if (stall_cnt !== '1) begin errors++; $display("FAIL sat_stall got=%0d want=15", stall_cnt); end
        mem_busy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            redirect = 1'b1;
            tick();
        end
        redirect = 1'b0;
        checks++; if (flush_cnt !== '1) begin errors++; $display("FAIL sat_flush got=%0d want=15", flush_cnt); end
        tick(); tick();
    endtask

    task automatic test_random();
        do_reset(); idle();
        m_sl = 0; m_fl = 0; m_stall = '0; m_flush = '0;
        for (int i = 0; i < 800; i++) begin
            rst          = ($urandom_range(99) != 0);
            ce           = ($urandom_range(9) != 0);
            mem_busy     = ($urandom_range(6) == 0);
            redirect     = ($urandom_range(9) == 0);
            id_rs        = AW'($urandom_range(3));
            id_rt        = AW'($urandom_range(3));
            id_use_rt    = 1'($urandom_range(1));
            ex_rs        = AW'($urandom_range(3));
            ex_rt        = AW'($urandom_range(3));
            ex_rd        = AW'($urandom_range(3));
            ex_regwr     = 1'($urandom_range(1));
            ex_memtoreg  = 1'($urandom_range(1));
            mem_rd       = AW'($urandom_range(3));
            mem_regwr    = 1'($urandom_range(1));
            mem_memtoreg = 1'($urandom_range(1));
            wb_rd        = AW'($urandom_range(3));
            wb_regwr     = 1'($urandom_range(1));
            #2;
            model_eval();
            checks++; if (ctl !== e_ctl) begin errors++; $display("FAIL rnd_ctl@%0d got=%b want=%b", i, ctl, e_ctl); end
            checks++; if (fwd_rs !== e_rs) begin errors++; $display("FAIL rnd_fwd_rs@%0d got=%b want=%b", i, fwd_rs, e_rs); end
            checks++; if (fwd_rt !== e_rt) begin errors++; $display("FAIL rnd_fwd_rt@%0d got=%b want=%b", i, fwd_rt, e_rt); end
            checks++; if (stall_cnt !== m_stall) begin errors++; $display("FAIL rnd_stall_cnt@%0d got=%0d want=%0d", i, stall_cnt, m_stall); end
            checks++; if (flush_cnt !== m_flush) begin errors++; $display("FAIL rnd_flush_cnt@%0d got=%0d want=%0d", i, flush_cnt, m_flush); end
            @(posedge clk);
            m_sl = n_sl; m_fl = n_fl; m_stall = n_stall; m_flush = n_flush;
            #1;
        end
        rst = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_forwarding();
        test_redirect();
        test_busy_in_stall();
        test_redirect_in_stall();
        test_ce();
        test_reset_in_flush();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
